flowstate_upd_sched: RTL and testbench

Read-modify-write scheduler for the flowstate tables. It accepts update requests from two requesters: the packet path and the CSR path. It arbitrates between them round-robin and reads the master flowstate copy. It computes the new value with two-deep write forwarding, then drives the broadcast write bus that keeps every flowstate RAM replica, master included, identical. The block sits between the reliability-TX control logic and the bank of flowstate RAMs, and is the only writer of the broadcast bus.

---
 rtl/flowstate_pkg.sv | 12 +
 rtl/flowstate_rr_arb2.sv | 37 +++
 rtl/flowstate_upd_sched.sv | 184 ++++++++++++++++++
 tb/tb_flowstate_upd_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flowstate_pkg.sv
// Shared opcodes and requester identifiers for the flowstate update scheduler.
package flowstate_pkg;

  localparam logic [1:0] OP_SET  = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  localparam logic SRC_PKT = 1'b0;
  localparam logic SRC_CSR = 1'b1;

endpackage

// File: rtl/flowstate_rr_arb2.sv
// Two-way round-robin arbiter between the packet path and the CSR path.
// A requester is granted unless the other one is also requesting and it is
// the other one's turn, so an idle arbiter shows both grants high.
module flowstate_rr_arb2
  import flowstate_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_pkt,
  input  logic req_csr,
  input  logic accept,
  output logic grant_pkt,
  output logic grant_csr
);

  logic last_r;

  // Grant decode from the last-grant pointer.
  always_comb begin
    grant_pkt = !(req_csr && (last_r == SRC_PKT));
    grant_csr = !(req_pkt && (last_r == SRC_CSR));
  end

  // Last-grant pointer moves only when a transfer is actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= SRC_CSR;
    end else if (accept && req_pkt && grant_pkt) begin
      last_r <= SRC_PKT;
    end else if (accept && req_csr && grant_csr) begin
      last_r <= SRC_CSR;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/flowstate_upd_sched.sv
// Read-modify-write scheduler for the flowstate tables: arbitrates between
// the packet and CSR requesters, reads the master copy, applies the opcode
// with two-deep write forwarding and drives the replica broadcast bus.
module flowstate_upd_sched
  import flowstate_pkg::*;
#(
  parameter int FLOWSTATE_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int OP_WIDTH        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      s_pkt_addr,
  input  logic [OP_WIDTH-1:0]        s_pkt_op,
  input  logic [FLOWSTATE_WIDTH-1:0] s_pkt_data,
  input  logic                       s_pkt_valid,
  output logic                       s_pkt_ready,
  input  logic [ADDR_WIDTH-1:0]      s_csr_addr,
  input  logic [OP_WIDTH-1:0]        s_csr_op,
  input  logic [FLOWSTATE_WIDTH-1:0] s_csr_data,
  input  logic                       s_csr_valid,
  output logic                       s_csr_ready,
  output logic [ADDR_WIDTH-1:0]      m_rd_addr,
  output logic                       m_rd_en,
  input  logic [FLOWSTATE_WIDTH-1:0] m_rd_data,
  output logic [ADDR_WIDTH-1:0]      bcd_addr_out,
  output logic [FLOWSTATE_WIDTH-1:0] bcd_flowstate_out,
  output logic                       bcd_valid_out,
  output logic [FLOWSTATE_WIDTH-1:0] m_rsp_data,
  output logic [ADDR_WIDTH-1:0]      m_rsp_addr,
  output logic                       m_rsp_src,
  output logic                       m_rsp_valid,
  input  logic                       m_rsp_ready
);

  logic                       open_s;
  logic                       grant_pkt_s;
  logic                       grant_csr_s;
  logic                       take_pkt_s;
  logic                       take_csr_s;
  logic                       accept_s;
  logic                       s1_is_read_s;
  logic                       s1_write_s;
  logic [FLOWSTATE_WIDTH-1:0] old_s;
  logic [FLOWSTATE_WIDTH-1:0] new_s;

  logic                       s1_valid_r;
  logic [ADDR_WIDTH-1:0]      s1_addr_r;
  logic [OP_WIDTH-1:0]        s1_op_r;
  logic [FLOWSTATE_WIDTH-1:0] s1_data_r;
  logic                       s1_src_r;

  logic                       bcd_valid_r;
  logic [ADDR_WIDTH-1:0]      bcd_addr_r;
  logic [FLOWSTATE_WIDTH-1:0] bcd_data_r;

  logic                       hist_valid_r;
  logic [ADDR_WIDTH-1:0]      hist_addr_r;
  logic [FLOWSTATE_WIDTH-1:0] hist_data_r;

  logic                       rsp_valid_r;
  logic [FLOWSTATE_WIDTH-1:0] rsp_data_r;
  logic [ADDR_WIDTH-1:0]      rsp_addr_r;
  logic                       rsp_src_r;

  // Accept gate: closed in reset, while a response is stuck, and while a READ
  // sits in compute (it will need the response register next cycle).
  always_comb begin
    s1_is_read_s = s1_valid_r && (s1_op_r == OP_WIDTH'(OP_READ));
    s1_write_s   = s1_valid_r && (s1_op_r != OP_WIDTH'(OP_READ));
    open_s       = !rst && !(rsp_valid_r && !m_rsp_ready) && !s1_is_read_s;
  end

  flowstate_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_pkt   (s_pkt_valid),
    .req_csr   (s_csr_valid),
    .accept    (open_s),
    .grant_pkt (grant_pkt_s),
    .grant_csr (grant_csr_s)
  );

  // Stage 0: handshake and combinational master-copy read for the winner.
  always_comb begin
    take_pkt_s  = open_s && s_pkt_valid && grant_pkt_s;
    take_csr_s  = open_s && s_csr_valid && grant_csr_s;
    accept_s    = take_pkt_s || take_csr_s;
    s_pkt_ready = open_s && grant_pkt_s;
    s_csr_ready = open_s && grant_csr_s;
    m_rd_en     = accept_s;
    if (take_csr_s) begin
      m_rd_addr = s_csr_addr;
    end else begin
      m_rd_addr = s_pkt_addr;
    end
  end

  // Stage 1 operand: newest pending write to the same address wins over RAM.
  always_comb begin
    if (bcd_valid_r && (bcd_addr_r == s1_addr_r)) begin
      old_s = bcd_data_r;
    end else if (hist_valid_r && (hist_addr_r == s1_addr_r)) begin
      old_s = hist_data_r;
    end else begin
      old_s = m_rd_data;
    end
    case (s1_op_r)
      OP_WIDTH'(OP_SET): new_s = s1_data_r;
      OP_WIDTH'(OP_CLR): new_s = {FLOWSTATE_WIDTH{1'b0}};
      OP_WIDTH'(OP_ADD): new_s = old_s + s1_data_r;
      default:           new_s = old_s;
    endcase
  end

  // Compute-stage request register, loaded with the granted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= {ADDR_WIDTH{1'b0}};
      s1_op_r    <= {OP_WIDTH{1'b0}};
      s1_data_r  <= {FLOWSTATE_WIDTH{1'b0}};
      s1_src_r   <= SRC_PKT;
    end else begin
      s1_valid_r <= accept_s;
      s1_addr_r  <= take_csr_s ? s_csr_addr : s_pkt_addr;
      s1_op_r    <= take_csr_s ? s_csr_op   : s_pkt_op;
      s1_data_r  <= take_csr_s ? s_csr_data : s_pkt_data;
      s1_src_r   <= take_csr_s ? SRC_CSR    : SRC_PKT;
    end
  end

  // Broadcast register plus one-deep history of the previous broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_valid_r  <= 1'b0;
      bcd_addr_r   <= {ADDR_WIDTH{1'b0}};
      bcd_data_r   <= {FLOWSTATE_WIDTH{1'b0}};
      hist_valid_r <= 1'b0;
      hist_addr_r  <= {ADDR_WIDTH{1'b0}};
      hist_data_r  <= {FLOWSTATE_WIDTH{1'b0}};
    end else begin
      bcd_valid_r  <= s1_write_s;
      if (s1_write_s) begin
        bcd_addr_r <= s1_addr_r;
        bcd_data_r <= new_s;
      end else begin
        bcd_addr_r <= bcd_addr_r;
        bcd_data_r <= bcd_data_r;
      end
      hist_valid_r <= bcd_valid_r;
      hist_addr_r  <= bcd_addr_r;
      hist_data_r  <= bcd_data_r;
    end
  end

  // Response register: loaded by a READ, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {FLOWSTATE_WIDTH{1'b0}};
      rsp_addr_r  <= {ADDR_WIDTH{1'b0}};
      rsp_src_r   <= SRC_PKT;
    end else if (s1_is_read_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= old_s;
      rsp_addr_r  <= s1_addr_r;
      rsp_src_r   <= s1_src_r;
    end else if (rsp_valid_r && m_rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign bcd_valid_out     = bcd_valid_r;
  assign bcd_addr_out      = bcd_addr_r;
  assign bcd_flowstate_out = bcd_data_r;
  assign m_rsp_valid       = rsp_valid_r;
  assign m_rsp_data        = rsp_data_r;
  assign m_rsp_addr        = rsp_addr_r;
  assign m_rsp_src         = rsp_src_r;

endmodule

// File: tb/tb_flowstate_upd_sched.sv
// Directed, table-driven bench for flowstate_upd_sched with a behavioural
// master-copy RAM (1-cycle read, read-before-write) fed by the broadcast bus.
module tb_flowstate_upd_sched;
  import flowstate_pkg::*;

  typedef struct {
    logic        pv;
    logic [1:0]  po;
    logic [9:0]  pa;
    logic [31:0] pd;
    logic        cv;
    logic [1:0]  co;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic        rr;
    logic        e_pr;
    logic        e_cr;
    logic        e_bv;
    logic [9:0]  e_ba;
    logic [31:0] e_bd;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [9:0]  e_ra;
    logic        e_rs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_init = 1'b1;
  logic [9:0]  s_pkt_addr = 10'd0;
  logic [1:0]  s_pkt_op = 2'd0;
  logic [31:0] s_pkt_data = 32'd0;
  logic        s_pkt_valid = 1'b0;
  logic        s_pkt_ready;
  logic [9:0]  s_csr_addr = 10'd0;
  logic [1:0]  s_csr_op = 2'd0;
  logic [31:0] s_csr_data = 32'd0;
  logic        s_csr_valid = 1'b0;
  logic        s_csr_ready;
  logic [9:0]  m_rd_addr;
  logic        m_rd_en;
  logic [31:0] m_rd_data;
  logic [9:0]  bcd_addr_out;
  logic [31:0] bcd_flowstate_out;
  logic        bcd_valid_out;
  logic [31:0] m_rsp_data;
  logic [9:0]  m_rsp_addr;
  logic        m_rsp_src;
  logic        m_rsp_valid;
  logic        m_rsp_ready = 1'b1;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;
  vec_t        vq[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  flowstate_upd_sched dut (
    .clk(clk), .rst(rst),
    .s_pkt_addr(s_pkt_addr), .s_pkt_op(s_pkt_op), .s_pkt_data(s_pkt_data),
    .s_pkt_valid(s_pkt_valid), .s_pkt_ready(s_pkt_ready),
    .s_csr_addr(s_csr_addr), .s_csr_op(s_csr_op), .s_csr_data(s_csr_data),
    .s_csr_valid(s_csr_valid), .s_csr_ready(s_csr_ready),
    .m_rd_addr(m_rd_addr), .m_rd_en(m_rd_en), .m_rd_data(m_rd_data),
    .bcd_addr_out(bcd_addr_out), .bcd_flowstate_out(bcd_flowstate_out),
    .bcd_valid_out(bcd_valid_out),
    .m_rsp_data(m_rsp_data), .m_rsp_addr(m_rsp_addr), .m_rsp_src(m_rsp_src),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready)
  );

  assign m_rd_data = rd_q;

  // Master-copy RAM: preload during init, then 1-cycle read-before-write.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[3]  <= 32'h0000_00AB;
      mem[5]  <= 32'd10;
      mem[7]  <= 32'd0;
      mem[9]  <= 32'd1;
      mem[11] <= 32'd100;
      mem[12] <= 32'd200;
      mem[13] <= 32'hFFFF_FFFF;
      rd_q    <= 32'd0;
    end else begin
      if (m_rd_en) rd_q <= mem[m_rd_addr];
      if (bcd_valid_out) mem[bcd_addr_out] <= bcd_flowstate_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add_vec(
    input logic pv, input logic [1:0] po, input logic [9:0] pa, input logic [31:0] pd,
    input logic cv, input logic [1:0] co, input logic [9:0] ca, input logic [31:0] cd,
    input logic rr, input logic e_pr, input logic e_cr,
    input logic e_bv, input logic [9:0] e_ba, input logic [31:0] e_bd,
    input logic e_rv, input logic [31:0] e_rd, input logic [9:0] e_ra, input logic e_rs);
    vec_t v;
    v.pv = pv; v.po = po; v.pa = pa; v.pd = pd;
    v.cv = cv; v.co = co; v.ca = ca; v.cd = cd;
    v.rr = rr; v.e_pr = e_pr; v.e_cr = e_cr;
    v.e_bv = e_bv; v.e_ba = e_ba; v.e_bd = e_bd;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_ra = e_ra; v.e_rs = e_rs;
    vq.push_back(v);
  endtask

  task automatic idle_in();
    s_pkt_valid = 1'b0; s_csr_valid = 1'b0;
    s_pkt_addr = 10'd0; s_pkt_op = 2'd0; s_pkt_data = 32'd0;
    s_csr_addr = 10'd0; s_csr_op = 2'd0; s_csr_data = 32'd0;
  endtask

  initial begin
    // Arbitration: both valid, pkt first after reset, strict alternation.
    add_vec(1'b1, OP_SET, 10'd20, 32'h100, 1'b1, OP_SET, 10'd30, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0,  32'h0,   1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_SET, 10'd21, 32'h101, 1'b1, OP_SET, 10'd30, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  32'h0,   1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_SET, 10'd21, 32'h101, 1'b1, OP_SET, 10'd31, 32'h201, 1'b1, 1'b1, 1'b0, 1'b1, 10'd20, 32'h100, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_SET, 10'd22, 32'h102, 1'b1, OP_SET, 10'd31, 32'h201, 1'b1, 1'b0, 1'b1, 1'b1, 10'd30, 32'h200, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_SET, 10'd22, 32'h102, 1'b1, OP_SET, 10'd32, 32'h202, 1'b1, 1'b1, 1'b0, 1'b1, 10'd21, 32'h101, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_SET, 10'd23, 32'h103, 1'b1, OP_SET, 10'd32, 32'h202, 1'b1, 1'b0, 1'b1, 1'b1, 10'd31, 32'h201, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_SET, 10'd23, 32'h103, 1'b1, OP_SET, 10'd33, 32'h203, 1'b1, 1'b1, 1'b0, 1'b1, 10'd22, 32'h102, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,   1'b1, OP_SET, 10'd33, 32'h203, 1'b1, 1'b0, 1'b1, 1'b1, 10'd32, 32'h202, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,   1'b0, OP_SET, 10'd0,  32'h0,   1'b1, 1'b1, 1'b1, 1'b1, 10'd23, 32'h103, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,   1'b0, OP_SET, 10'd0,  32'h0,   1'b1, 1'b1, 1'b1, 1'b1, 10'd33, 32'h203, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,   1'b0, OP_SET, 10'd0,  32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 10'd0,  32'h0,   1'b0, 32'h0, 10'd0, 1'b0);
    // ADD chain on address 5 (master 10): 11, 12, 13.
    add_vec(1'b1, OP_ADD, 10'd5, 32'd1, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_ADD, 10'd5, 32'd1, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0,  1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_ADD, 10'd5, 32'd1, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd5, 32'd11, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'd0, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd5, 32'd12, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'd0, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd5, 32'd13, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'd0, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0,  1'b0, 32'h0, 10'd0, 1'b0);
    // Gap forwarding through the history register: SET 7=0x55, idle, ADD 7 +1.
    add_vec(1'b1, OP_SET, 10'd7, 32'h55, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0,  1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'h0,  1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0,  1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_ADD, 10'd7, 32'h1,  1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd7, 32'h55, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'h0,  1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0,  1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'h0,  1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd7, 32'h56, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'h0,  1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0,  1'b0, 32'h0, 10'd0, 1'b0);
    // Back-to-back ADDs to different addresses, plus carry-dropping wrap.
    add_vec(1'b1, OP_ADD, 10'd11, 32'd3, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0,  32'd0,   1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_ADD, 10'd12, 32'd3, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0,  32'd0,   1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_ADD, 10'd13, 32'd2, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd11, 32'd103, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'd0, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd12, 32'd203, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'd0, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd13, 32'd1,   1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'd0, 1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0,  32'd0,   1'b0, 32'h0, 10'd0, 1'b0);
    // CLR between ADDs on address 9 (master 1): 5, 0, 2.
    add_vec(1'b1, OP_ADD, 10'd9, 32'd4,      1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_CLR, 10'd9, 32'hDEAD,   1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b1, OP_ADD, 10'd9, 32'd2,      1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd9, 32'd5, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'd0,      1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd9, 32'd0, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'd0,      1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd9, 32'd2, 1'b0, 32'h0, 10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0, 32'd0,      1'b0, OP_SET, 10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 32'h0, 10'd0, 1'b0);
    // CSR READ of address 3 under response backpressure; pkt SET 40 waits.
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,  1'b1, OP_READ, 10'd3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,  32'h0,  1'b0, 32'h0,  10'd0, 1'b0);
    add_vec(1'b1, OP_SET, 10'd40, 32'h77, 1'b0, OP_SET,  10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,  32'h0,  1'b0, 32'h0,  10'd0, 1'b0);
    for (int k = 0; k < 4; k++)
      add_vec(1'b1, OP_SET, 10'd40, 32'h77, 1'b0, OP_SET, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 32'hAB, 10'd3, 1'b1);
    add_vec(1'b1, OP_SET, 10'd40, 32'h77, 1'b0, OP_SET,  10'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0,  32'h0,  1'b1, 32'hAB, 10'd3, 1'b1);
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,  1'b0, OP_SET,  10'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,  32'h0,  1'b0, 32'h0,  10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,  1'b0, OP_SET,  10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd40, 32'h77, 1'b0, 32'h0,  10'd0, 1'b0);
    add_vec(1'b0, OP_SET, 10'd0,  32'h0,  1'b0, OP_SET,  10'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0,  32'h0,  1'b0, 32'h0,  10'd0, 1'b0);

    // Power-on reset: ready low while reset, reset values on the registers.
    idle_in();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pkt_ready", {31'd0, s_pkt_ready}, 32'd0);
    chk("reset_csr_ready", {31'd0, s_csr_ready}, 32'd0);
    chk("reset_bcd_valid", {31'd0, bcd_valid_out}, 32'd0);
    chk("reset_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; tb_init = 1'b0;
    #1;
    chk("idle_pkt_ready", {31'd0, s_pkt_ready}, 32'd1);
    chk("idle_csr_ready", {31'd0, s_csr_ready}, 32'd1);
    chk("idle_rd_en", {31'd0, m_rd_en}, 32'd0);

    // Table-driven per-cycle vectors.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      s_pkt_valid = vq[i].pv; s_pkt_op = vq[i].po; s_pkt_addr = vq[i].pa; s_pkt_data = vq[i].pd;
      s_csr_valid = vq[i].cv; s_csr_op = vq[i].co; s_csr_addr = vq[i].ca; s_csr_data = vq[i].cd;
      m_rsp_ready = vq[i].rr;
      #1;
      chk($sformatf("v%0d_pkt_ready", i), {31'd0, s_pkt_ready}, {31'd0, vq[i].e_pr});
      chk($sformatf("v%0d_csr_ready", i), {31'd0, s_csr_ready}, {31'd0, vq[i].e_cr});
      chk($sformatf("v%0d_bcd_valid", i), {31'd0, bcd_valid_out}, {31'd0, vq[i].e_bv});
      if (vq[i].e_bv) begin
        chk($sformatf("v%0d_bcd_addr", i), {22'd0, bcd_addr_out}, {22'd0, vq[i].e_ba});
        chk($sformatf("v%0d_bcd_data", i), bcd_flowstate_out, vq[i].e_bd);
      end
      chk($sformatf("v%0d_rsp_valid", i), {31'd0, m_rsp_valid}, {31'd0, vq[i].e_rv});
      if (vq[i].e_rv) begin
        chk($sformatf("v%0d_rsp_data", i), m_rsp_data, vq[i].e_rd);
        chk($sformatf("v%0d_rsp_addr", i), {22'd0, m_rsp_addr}, {22'd0, vq[i].e_ra});
        chk($sformatf("v%0d_rsp_src", i), {31'd0, m_rsp_src}, {31'd0, vq[i].e_rs});
      end
    end

    // Reset in the compute cycle of an accepted SET: it must never broadcast.
    @(negedge clk);
    m_rsp_ready = 1'b1;
    s_pkt_valid = 1'b1; s_pkt_op = OP_SET; s_pkt_addr = 10'd50; s_pkt_data = 32'h99;
    #1;
    chk("mid_accept_ready", {31'd0, s_pkt_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    s_pkt_addr = 10'd51; s_pkt_data = 32'h9A;
    #1;
    chk("mid_rst_pkt_ready", {31'd0, s_pkt_ready}, 32'd0);
    chk("mid_rst_csr_ready", {31'd0, s_csr_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    #1;
    chk("post_rst_bcd_valid", {31'd0, bcd_valid_out}, 32'd0);
    chk("post_rst_bcd_addr", {22'd0, bcd_addr_out}, 32'd0);
    chk("post_rst_bcd_data", bcd_flowstate_out, 32'd0);
    chk("post_rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    chk("post_rst_rsp_data", m_rsp_data, 32'd0);
    chk("post_rst_rsp_addr", {22'd0, m_rsp_addr}, 32'd0);
    chk("post_rst_rsp_src", {31'd0, m_rsp_src}, 32'd0);
    chk("post_rst_rd_en", {31'd0, m_rd_en}, 32'd0);
    chk("post_rst_pkt_ready", {31'd0, s_pkt_ready}, 32'd1);
    @(negedge clk);
    s_pkt_valid = 1'b1; s_pkt_op = OP_SET; s_pkt_addr = 10'd52; s_pkt_data = 32'h33;
    #1;
    chk("post_rst_accept", {31'd0, s_pkt_ready}, 32'd1);
    chk("post_rst_csr_turn", {31'd0, s_csr_ready}, 32'd0);
    chk("post_rst_rd_addr", {22'd0, m_rd_addr}, 32'd52);
    chk("post_rst_no_stale_bcd", {31'd0, bcd_valid_out}, 32'd0);
    @(negedge clk);
    idle_in();
    #1;
    chk("post_rst_gap_bcd", {31'd0, bcd_valid_out}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_bcd_valid2", {31'd0, bcd_valid_out}, 32'd1);
    chk("post_rst_bcd_addr2", {22'd0, bcd_addr_out}, 32'd52);
    chk("post_rst_bcd_data2", bcd_flowstate_out, 32'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
